// File: rtl/ahb_dbg_pkg.sv
// Shared AHB-lite encodings and the FSM state type for the debug AHB arbiter.
// Latency: none (package only).
// Backpressure: n/a.
package ahb_dbg_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/ahb_dbg_arbiter_sel_decode.sv
// Wishbone byte-select to AHB hsize / low address offset decoder.
// Latency: combinational.
// Backpressure: n/a.
// Ports: sel (byte lanes) -> hsize, offset (haddr[1:0]), illegal (unsupported lane pattern).
module wb_sel_decode
  import ahb_dbg_pkg::*;
(
  input  logic [3:0] sel,
  output logic [2:0] hsize,
  output logic [1:0] offset,
  output logic       illegal
);

  always_comb begin
    hsize   = HSIZE_BYTE;
    offset  = 2'b00;
    illegal = 1'b0;
    case (sel)
      4'b1111: hsize = HSIZE_WORD;
      4'b0011: hsize = HSIZE_HALF;
      4'b1100: begin hsize = HSIZE_HALF; offset = 2'b10; end
      4'b0001: offset = 2'b00;
      4'b0010: offset = 2'b01;
      4'b0100: offset = 2'b10;
      4'b1000: offset = 2'b11;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_dbg_arbiter.sv
// Two-port Wishbone -> AHB-lite master arbiter; each request is one SINGLE NONSEQ transfer.
// Latency: zero-wait request sampled at edge 0 gives ack in cycle 3; each hready=0 cycle adds one.
// Backpressure: losing port holds stb until granted; hready=0 stalls ADDR/DATA indefinitely.
// Ports: m0_*/m1_* Wishbone slaves (port 0 host, port 1 SWD/JTAG), h* AHB-lite master, busy_o.
module ahb_dbg_arbiter
  import ahb_dbg_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [AWIDTH-1:0] m0_addr_i,
  input  logic [DWIDTH-1:0] m0_data_i,
  output logic [DWIDTH-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [AWIDTH-1:0] m1_addr_i,
  input  logic [DWIDTH-1:0] m1_data_i,
  output logic [DWIDTH-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [AWIDTH-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DWIDTH-1:0] hwdata,
  input  logic [DWIDTH-1:0] hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp,
  output logic              busy_o
);

  state_t state_q, state_d;

  logic              gnt_q, last_gnt_q, done_q;
  logic              we_q, err_q;
  logic [AWIDTH-1:2] addr_q;
  logic [1:0]        off_q;
  logic [2:0]        size_q;
  logic [DWIDTH-1:0] wdata_q, rdata_q;

  logic req0, req1, gnt_d, any_req;
  logic [3:0] sel_mux;
  logic [2:0] dec_size;
  logic [1:0] dec_off;
  logic       dec_illegal;

  // Byte offset comes from sel, so the requesters' low address bits are ignored.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

  // In the IDLE cycle right after a response, the port just served may still
  // show its old stb; masking it keeps a stale request from being re-granted.
  assign req0 = m0_cyc_i & m0_stb_i & ~(done_q & ~gnt_q);
  assign req1 = m1_cyc_i & m1_stb_i & ~(done_q &  gnt_q);

  assign any_req = req0 | req1;
  // Contention goes to the port that was not granted last.
  assign gnt_d   = (req0 & req1) ? ~last_gnt_q : req1;
  assign sel_mux = gnt_d ? m1_sel_i : m0_sel_i;

  wb_sel_decode u_sel_decode (
    .sel     (sel_mux),
    .hsize   (dec_size),
    .offset  (dec_off),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = dec_illegal ? ST_RESP : ST_ADDR;
      ST_ADDR: if (hready)  state_d = ST_DATA;
      ST_DATA: if (hready)  state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      off_q      <= 2'b00;
      size_q     <= HSIZE_BYTE;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      done_q <= (state_q == ST_RESP);
      if (state_q == ST_IDLE && any_req) begin
        gnt_q      <= gnt_d;
        last_gnt_q <= gnt_d;
        we_q       <= gnt_d ? m1_we_i : m0_we_i;
        addr_q     <= gnt_d ? m1_addr_i[AWIDTH-1:2] : m0_addr_i[AWIDTH-1:2];
        wdata_q    <= gnt_d ? m1_data_i : m0_data_i;
        size_q     <= dec_size;
        off_q      <= dec_off;
        err_q      <= dec_illegal;
      end
      if (state_q == ST_DATA && hready) begin
        err_q <= (hresp == HRESP_ERROR);
        // An errored read leaves the previous read data in place.
        if (!we_q && hresp == HRESP_OKAY) rdata_q <= hrdata;
      end
    end
  end

  assign htrans = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr  = {addr_q, off_q};
  assign hwrite = we_q;
  assign hsize  = size_q;
  assign hburst = HBURST_SINGLE;
  assign hwdata = wdata_q;
  assign busy_o = (state_q != ST_IDLE);

  // Responses are gated by cyc so an abandoned cycle gets no ack/err.
  assign m0_ack_o  = (state_q == ST_RESP) & ~gnt_q & ~err_q & m0_cyc_i;
  assign m0_err_o  = (state_q == ST_RESP) & ~gnt_q &  err_q & m0_cyc_i;
  assign m1_ack_o  = (state_q == ST_RESP) &  gnt_q & ~err_q & m1_cyc_i;
  assign m1_err_o  = (state_q == ST_RESP) &  gnt_q &  err_q & m1_cyc_i;
  assign m0_data_o = rdata_q;
  assign m1_data_o = rdata_q;

endmodule

// File: tb/tb_ahb_dbg_arbiter.sv
// Directed bench for ahb_dbg_arbiter: expected Wishbone responses are queued by
// the stimulus and popped by a negedge monitor; phase timing is checked inline.
module tb_ahb_dbg_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [3:0]  m0_sel_i = 0;
  logic [31:0] m0_addr_i = 0, m0_data_i = 0;
  logic [31:0] m0_data_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [3:0]  m1_sel_i = 0;
  logic [31:0] m1_addr_i = 0, m1_data_i = 0;
  logic [31:0] m1_data_o;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hrdata = 0;
  logic        hready = 1'b1;
  logic [1:0]  hresp = 2'b00;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic        is_err;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk_i = ~clk_i;

  ahb_dbg_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp), .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic chk_resp(input int p, input logic ack, input logic err, input logic [31:0] d);
    exp_t x;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL resp_unexpected: port %0d ack=%0b err=%0b data=0x%08h, expected no response",
               p, ack, err, d);
    end else begin
      x = exp_q.pop_front();
      if (x.port != p || x.is_err !== err || ack === err || d !== x.data) begin
        errors++;
        $display("FAIL resp_port%0d: got ack=%0b err=%0b data=0x%08h, expected port %0d err=%0b data=0x%08h",
                 p, ack, err, d, x.port, x.is_err, x.data);
      end
    end
  endtask

  // Monitor: every response strobe must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m0_ack_o || m0_err_o) chk_resp(0, m0_ack_o, m0_err_o, m0_data_o);
      if (m1_ack_o || m1_err_o) chk_resp(1, m1_ack_o, m1_err_o, m1_data_o);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_port(input int p, input logic act, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] dat);
    if (p == 0) begin
      m0_cyc_i = act; m0_stb_i = act; m0_we_i = we; m0_sel_i = sel;
      m0_addr_i = addr; m0_data_i = dat;
    end else begin
      m1_cyc_i = act; m1_stb_i = act; m1_we_i = we; m1_sel_i = sel;
      m1_addr_i = addr; m1_data_i = dat;
    end
  endtask

  task automatic push(input int p, input logic e, input logic [31:0] d);
    exp_t x;
    x.port = p; x.is_err = e; x.data = d;
    exp_q.push_back(x);
  endtask

  initial begin
    tick(); tick();
    // Reset state
    chk("rst_htrans", {30'd0, htrans}, 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwrite", {31'd0, hwrite}, 32'h0);
    chk("rst_hsize", {29'd0, hsize}, 32'h0);
    chk("rst_hburst", {29'd0, hburst}, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_resp", {28'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'h0);
    chk("rst_data", m0_data_o, 32'h0);
    chk("rst_busy", {31'd0, busy_o}, 32'h0);
    rst_i = 1'b0;
    tick();

    // 1: port 0 zero-wait word read
    set_port(0, 1, 0, 4'b1111, 32'h2000_0010, 32'h0);
    hrdata = 32'hDEAD_BEEF;
    push(0, 0, 32'hDEAD_BEEF);
    tick();
    chk("t1_htrans_c1", {30'd0, htrans}, 32'h2);
    chk("t1_haddr", haddr, 32'h2000_0010);
    chk("t1_hsize", {29'd0, hsize}, 32'h2);
    chk("t1_hwrite", {31'd0, hwrite}, 32'h0);
    chk("t1_busy", {31'd0, busy_o}, 32'h1);
    tick();
    chk("t1_htrans_c2", {30'd0, htrans}, 32'h0);
    tick();
    chk("t1_ack_c3", {31'd0, m0_ack_o}, 32'h1);
    tick();
    set_port(0, 0, 0, 4'b0000, 32'h0, 32'h0);
    chk("t1_ack_c4", {31'd0, m0_ack_o}, 32'h0);
    tick();

    // 2: port 1 byte write, two DATA wait states
    set_port(1, 1, 1, 4'b0100, 32'h0000_0100, 32'h00AB_0000);
    push(1, 0, 32'hDEAD_BEEF);
    tick();
    chk("t2_haddr", haddr, 32'h0000_0102);
    chk("t2_hsize", {29'd0, hsize}, 32'h0);
    chk("t2_hwrite", {31'd0, hwrite}, 32'h1);
    chk("t2_htrans", {30'd0, htrans}, 32'h2);
    tick();
    hready = 1'b0;
    chk("t2_hwdata_c2", hwdata, 32'h00AB_0000);
    tick();
    chk("t2_hwdata_c3", hwdata, 32'h00AB_0000);
    chk("t2_htrans_c3", {30'd0, htrans}, 32'h0);
    tick();
    hready = 1'b1;
    chk("t2_hwdata_c4", hwdata, 32'h00AB_0000);
    chk("t2_noack_c4", {31'd0, m1_ack_o}, 32'h0);
    tick();
    chk("t2_ack_c5", {31'd0, m1_ack_o}, 32'h1);
    tick();
    set_port(1, 0, 0, 4'b0000, 32'h0, 32'h0);
    tick();

    // 3: contention straight out of reset, then alternating grants
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    hrdata = 32'h0000_1234;
    set_port(0, 1, 0, 4'b1111, 32'h0000_0010, 32'h0);
    set_port(1, 1, 0, 4'b1111, 32'h0000_0020, 32'h0);
    push(0, 0, 32'h0000_1234);
    push(1, 0, 32'h0000_1234);
    push(0, 0, 32'h0000_1234);
    tick();
    chk("t3_first_p0", haddr, 32'h0000_0010);
    tick(); tick();
    chk("t3_ack_p0", {31'd0, m0_ack_o}, 32'h1);
    tick();
    set_port(0, 0, 0, 4'b0000, 32'h0, 32'h0);
    tick();
    chk("t3_second_p1", haddr, 32'h0000_0020);
    set_port(0, 1, 0, 4'b1111, 32'h0000_0010, 32'h0);
    tick(); tick();
    chk("t3_ack_p1", {31'd0, m1_ack_o}, 32'h1);
    tick();
    set_port(1, 0, 0, 4'b0000, 32'h0, 32'h0);
    tick();
    chk("t3_third_p0", haddr, 32'h0000_0010);
    tick(); tick();
    tick();
    set_port(0, 0, 0, 4'b0000, 32'h0, 32'h0);
    tick();

    // 4: two-cycle ERROR response on a port 0 read
    hrdata = 32'hBAD0_BAD0;
    set_port(0, 1, 0, 4'b1111, 32'h0000_0030, 32'h0);
    push(0, 1, 32'h0000_1234);
    tick();
    tick();
    hready = 1'b0; hresp = 2'b01;
    tick();
    chk("t4_no_new_trans", {30'd0, htrans}, 32'h0);
    hready = 1'b1; hresp = 2'b01;
    tick();
    chk("t4_err", {30'd0, m0_err_o, m0_ack_o}, 32'h2);
    hresp = 2'b00;
    tick();
    set_port(0, 0, 0, 4'b0000, 32'h0, 32'h0);
    chk("t4_err_gone", {31'd0, m0_err_o}, 32'h0);
    tick();

    // 5: illegal sel on port 1, no AHB transfer
    set_port(1, 1, 1, 4'b0101, 32'h0000_0040, 32'h1);
    push(1, 1, 32'h0000_1234);
    chk("t5_htrans_c0", {30'd0, htrans}, 32'h0);
    tick();
    chk("t5_err_c1", {31'd0, m1_err_o}, 32'h1);
    chk("t5_htrans_c1", {30'd0, htrans}, 32'h0);
    tick();
    set_port(1, 0, 0, 4'b0000, 32'h0, 32'h0);
    chk("t5_err_c2", {31'd0, m1_err_o}, 32'h0);
    chk("t5_htrans_c2", {30'd0, htrans}, 32'h0);
    tick();

    // 6: cyc dropped mid-transfer: AHB completes, no response
    hrdata = 32'h0000_0077;
    set_port(0, 1, 0, 4'b1111, 32'h0000_0060, 32'h0);
    tick();
    chk("t6_htrans", {30'd0, htrans}, 32'h2);
    tick();
    set_port(0, 0, 0, 4'b0000, 32'h0, 32'h0);
    tick();
    chk("t6_no_ack", {31'd0, m0_ack_o}, 32'h0);
    chk("t6_busy_resp", {31'd0, busy_o}, 32'h1);
    tick();
    chk("t6_idle", {31'd0, busy_o}, 32'h0);
    tick();

    // 7: reset during DATA of a write, then a normal request
    set_port(0, 1, 1, 4'b1111, 32'h0000_0080, 32'hCAFE_F00D);
    tick();
    tick();
    hready = 1'b0;
    chk("t7_hwdata_pre", hwdata, 32'hCAFE_F00D);
    rst_i = 1'b1;
    #1;
    chk("t7_rst_htrans", {30'd0, htrans}, 32'h0);
    chk("t7_rst_busy", {31'd0, busy_o}, 32'h0);
    chk("t7_rst_hwdata", hwdata, 32'h0);
    tick();
    rst_i = 1'b0;
    hready = 1'b1;
    set_port(0, 0, 0, 4'b0000, 32'h0, 32'h0);
    tick();
    hrdata = 32'h5555_AAAA;
    set_port(1, 1, 0, 4'b0011, 32'h0000_0052, 32'h0);
    push(1, 0, 32'h5555_AAAA);
    tick();
    chk("t7_haddr", haddr, 32'h0000_0050);
    chk("t7_hsize", {29'd0, hsize}, 32'h1);
    tick(); tick();
    chk("t7_ack", {31'd0, m1_ack_o}, 32'h1);
    tick();
    set_port(1, 0, 0, 4'b0000, 32'h0, 32'h0);
    tick(); tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL resp_missing: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_dbg_arbiter.md
# ahb_dbg_arbiter

Two-port Wishbone-to-AHB-lite master arbiter and transfer sequencer for the Nrv32 debug AHB path. It shares one AHB master port between two Wishbone requesters:

- port 0: testbench/host debug access;
- port 1: the SWD/JTAG transport.

Each accepted request becomes a single NONSEQ AHB transfer with wait-state and ERROR handling. It replaces the fake bridge wherever real sequencing of debug-system accesses is needed.

## Interface
- AWIDTH, 32, address width (≥ 3)
- DWIDTH, 32, data width (fixed 32; hsize encoding assumes it)
- clk_i  in  1  single clock for both Wishbone and AHB sides
- rst_i  in  1  asynchronous, active-high reset
- mN_cyc_i  in  1  Wishbone cycle, N = 0, 1
- mN_stb_i  in  1  Wishbone strobe
- mN_we_i  in  1  write when 1
- mN_sel_i  in  4  byte lanes
- mN_addr_i  in  AWIDTH  byte address
- mN_data_i  in  DWIDTH  write data
- mN_data_o  out  DWIDTH  read data (shared capture register)
- mN_ack_o  out  1  transfer done, OKAY
- mN_err_o  out  1  transfer done, ERROR or illegal sel
- haddr  out  AWIDTH  AHB address
- htrans  out  2  IDLE (00) or NONSEQ (10) only
- hwrite  out  1  AHB direction
- hsize  out  3  000 byte, 001 half, 010 word
- hburst  out  3  constant 000 (SINGLE)
- hwdata  out  32  write data, data phase
- hrdata  in  32  read data
- hready  in  1  transfer ready
- hresp  in  2  00 OKAY, 01 ERROR
- busy_o  out  1  state ≠ IDLE

## Operation
- **FSM states:** IDLE, ADDR, DATA, RESP.
- **Request:** reqN = mN_cyc_i & mN_stb_i.
- **IDLE, arbitration:**
  - Only one port requesting: grant that port.
  - Both requesting: grant the port ≠ last_gnt (round-robin).
  - Latch grant, we, addr, wdata and decoded size into registers; update last_gnt.
- **Sel decode (IDLE):**
  - 1111: word, offset 00.
  - 0011 / 1100: half, offset 00 / 10.
  - 0001 / 0010 / 0100 / 1000: byte, offset 00 / 01 / 10 / 11.
  - Any other pattern is illegal: go to RESP with err set and issue no AHB transfer.
- **haddr:** {addr[AWIDTH-1:2], offset}.
- **ADDR:**
  - Drive htrans=NONSEQ, haddr, hwrite, hsize.
  - hready=1: go to DATA. Otherwise hold all address-phase signals stable.
- **DATA:**
  - htrans=IDLE; hwdata = latched wdata, held until completion.
  - hready=1: capture hrdata into the data register (reads only).
  - Set err = (hresp==ERROR), then go to RESP.
  - hready=0 with hresp=ERROR (first error cycle): keep waiting, no new transfer.
- **RESP:**
  - Pulse mG_ack_o or mG_err_o for exactly one cycle, only if mG_cyc_i is still 1. If cyc was dropped, the response is suppressed.
  - Then go to IDLE.
- **No back-to-back pipelining:** a new address phase never overlaps a data phase.
- **Reset values:**
  - htrans=00, haddr=0, hwrite=0, hsize=0, hburst=0, hwdata=0.
  - All ack/err = 0, data_o = 0, busy_o = 0.
  - State = IDLE, last_gnt = 1, so port 0 wins the first contention.

## Timing
- **Zero-wait latency:** stb sampled in IDLE at edge 0 → ADDR at 1 → DATA at 2 → RESP (ack high) at 3 → IDLE at 4.
- **Wait states:** each hready=0 cycle in ADDR or DATA adds one cycle.
- **Illegal sel:** err_o high 1 cycle after the sampling edge.
- **Read data:** data_o is valid in the ack cycle and held until the next read completes.
- **Wishbone master rule:** deassert stb in the cycle after ack/err. The IDLE cycle after RESP must not re-grant a stale request.
- **Simultaneous requests:** resolved in one cycle; the loser waits with stb held and no timeout.
- **cyc dropped mid-transfer:** the AHB transfer still completes; no ack or err is given.
- **Reset mid-transfer:** outputs return to reset values asynchronously (htrans=IDLE at once) and the transfer is abandoned.

## Structure
- **Package ahb_dbg_pkg:**
  - HTRANS_IDLE/NONSEQ, HSIZE_BYTE/HALF/WORD, HBURST_SINGLE, HRESP_OKAY/ERROR.
  - FSM state encoding (2-bit).
- **Sub-module wb_sel_decode** (combinational): sel[3:0] → hsize, offset[1:0], illegal. Instantiated once on the granted port's sel.

## Test plan
- Port 0 word read at 0x2000_0010, hrdata=0xDEADBEEF, hready=1 → htrans=10 at cycle 1, m0_ack_o at cycle 3, m0_data_o=0xDEADBEEF.
- Port 1 byte write, sel=0100, addr=0x100, data=0x00AB0000, 2 wait states in DATA → haddr=0x102, hsize=000, hwdata stable, m1_ack_o at cycle 5.
- Both request in the same cycle from reset → port 0 served first. Then, with both still requesting, port 1 is served next and port 0 after that (alternating grants).
- Two-cycle ERROR response (hready=0/hresp=01, then hready=1/hresp=01) → m0_err_o for 1 cycle, no ack, data_o unchanged.
- sel=0101 → m1_err_o 1 cycle later, htrans stays 00 throughout.
- rst_i asserted during DATA of a write → htrans=00, busy_o=0 immediately. The next request after release runs normally.
